spi_pixel_receiver: RTL and testbench
=====================================

# spi_pixel_receiver

- Upstream neighbour of the pixel deserializer.
- Receives the microcontroller's SPI mode-0 byte stream on the single system clock and delivers each completed byte on DATA_OUT with a one-cycle BYTE_VALID strobe.
- Tracks the 3-byte pixel packet (x, y, color) and raises PIXEL_DONE once the third byte has settled, so the deserializer is written per byte and commits to VGA once per packet.

## Interface

Parameters:
- SYNC_STAGES, 2, flip-flops per input synchronizer chain; legal range 2..4.
- MSB_FIRST, 1, 1 = bit 7 received first; 0 = bit 0 first.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- SPI_SCK  in  1  SPI clock, asynchronous to CLK, idle low.
- SPI_CS_N  in  1  chip select, active low, asynchronous.
- SPI_MOSI  in  1  serial data, asynchronous.
- SPI_MISO  out  1  echo output (see Configuration).
- DATA_OUT  out  8  last completed byte; held until the next completed byte.
- BYTE_VALID  out  1  one-cycle pulse per completed byte.
- BYTE_INDEX  out  2  packet position of the byte on DATA_OUT: 0 = x, 1 = y, 2 = color.
- PIXEL_DONE  out  1  one-cycle pulse one CLK cycle after the BYTE_VALID carrying index 2.
- ACTIVE  out  1  synchronized CS asserted.
- FRAME_ERR  out  1  sticky error flag; cleared only by RST.

## Operation

- **Synchronizers:** each SPI input passes through SYNC_STAGES flops.
  - Reset values: SCK 0, CS_N 1, MOSI 0.
  - A further flop on synced SCK and synced CS_N supplies the previous value for edge detection.
- **Frame start:** on a synced CS_N falling edge:
  - bit counter cleared to 0;
  - packet index cleared to 0;
  - ACTIVE set to 1.
- **Bit capture:** on a synced SCK rising edge while synced CS_N = 0:
  - synced MOSI shifts into the shift register (MSB_FIRST selects shift direction);
  - bit counter increments modulo 8.
  - SCK edges while CS_N = 1 are ignored.
- **Byte completion** (8th bit captured):
  - next cycle, DATA_OUT is loaded, BYTE_VALID = 1 and BYTE_INDEX = the current packet index;
  - packet index then advances 0→1→2→0.
- **Packet completion:** PIXEL_DONE pulses in the cycle after a BYTE_VALID with BYTE_INDEX = 2.
- **Frame end:** on a synced CS_N rising edge:
  - ACTIVE is cleared;
  - any partial byte is discarded and no BYTE_VALID is issued;
  - if bit counter ≠ 0 or packet index ≠ 0, FRAME_ERR is set.
- **Back-to-back packets:** multiple packets per CS frame are legal; the index wraps.
- **Reset values:**
  - DATA_OUT 0x00, BYTE_VALID 0, BYTE_INDEX 0, PIXEL_DONE 0, ACTIVE 0, FRAME_ERR 0, SPI_MISO 0;
  - all internal counters and registers cleared.

## Timing

- **Byte latency:** pin-level SCK rising edge of bit 8 → BYTE_VALID high is SYNC_STAGES + 2 CLK cycles.
- **Packet latency:** PIXEL_DONE follows that BYTE_VALID by exactly 1 cycle.
- **SCK constraint:** SPI_SCK high and low phases must each last ≥ SYNC_STAGES + 1 CLK periods. Faster SCK is unsupported and behaviour is undefined.
- **CS setup:** SPI_CS_N must fall ≥ SYNC_STAGES + 1 CLK periods before the first SCK rising edge.
- **Simultaneous events:**
  - Synced SCK rise in the same cycle as synced CS_N rise: CS_N wins; the bit is discarded and the FRAME_ERR rule applies to the pre-edge counter.
  - Synced CS_N fall in the same cycle as SCK rise: counters clear; the SCK edge is ignored.
- **RST:** a high RST in any cycle overrides all activity. A frame interrupted by reset resumes only after the next CS_N falling edge.

## Configuration

- **SPI_RX_MISO_ECHO_EN defined:**
  - SPI_MISO shifts out the previously completed byte, in the same bit order, one bit per synced SCK falling edge while CS_N = 0;
  - the first bit is presented on the synced CS_N falling edge;
  - before any byte has completed, zeros are shifted out;
  - lets the microcontroller verify each byte.
- **SPI_RX_MISO_ECHO_EN not defined:** SPI_MISO is tied to 0 and no echo logic is synthesized.

## Test plan

- **Reset:** hold RST 3 cycles with inputs idle → all outputs at reset values; ACTIVE 0.
- **Single packet:** one CS frame, bytes 0x15, 0x2A, 0xC3, MSB_FIRST = 1 →
  - three BYTE_VALID pulses, DATA_OUT 0x15/0x2A/0xC3, BYTE_INDEX 0/1/2;
  - one PIXEL_DONE, one cycle after the third BYTE_VALID;
  - FRAME_ERR 0.
- **Back-to-back packets:** two packets (6 bytes) in one frame → BYTE_INDEX sequence 0,1,2,0,1,2; two PIXEL_DONE pulses.
- **Abort mid-byte:** CS_N rises after 5 bits of the second byte → no BYTE_VALID for the partial byte; FRAME_ERR = 1 and stays 1; the next frame starts at BYTE_INDEX 0.
- **Bit order and gating:**
  - MSB_FIRST = 0 with byte 0x01 sent LSB-first → DATA_OUT 0x01;
  - SCK toggles while CS_N high → no BYTE_VALID.
- **Echo:** with SPI_RX_MISO_ECHO_EN, send 0xA5 then 0x3C → MISO during the second byte carries 0xA5 MSB-first. Without the macro, MISO stays 0.

Source files
------------

// File: rtl/spi_pixel_receiver.sv
// rtl/spi_pixel_receiver.sv - SPI mode-0 byte receiver with 3-byte pixel packet tracking
// Optional MISO echo of the previous byte is built when SPI_RX_MISO_ECHO_EN is defined.
module spi_pixel_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_sck_i,
    input  logic       spi_cs_n_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic [7:0] data_o,
    output logic       byte_valid_o,
    output logic [1:0] byte_index_o,
    output logic       pixel_done_o,
    output logic       active_o,
    output logic       frame_err_o
);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   csn_prev_q;

    logic       sck_s, csn_s, mosi_s;
    logic       sck_rise, csn_fall, csn_rise, capture;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, shift_next;
    logic       pend_q, pend_d;
    logic [1:0] pkt_q, pkt_d, pkt_inc, pkt_eff;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic [1:0] index_q, index_d;
    logic       pd_q, pd_d;
    logic       active_q, active_d;
    logic       err_q, err_d;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise = sck_s & ~sck_prev_q;
    assign csn_fall = csn_prev_q & ~csn_s;
    assign csn_rise = ~csn_prev_q & csn_s;
    // Gating on active_q keeps a reset-interrupted frame silent until a fresh CS fall.
    assign capture  = sck_rise & ~csn_s & active_q;

    assign shift_next = MSB_FIRST ? {shift_q[6:0], mosi_s} : {mosi_s, shift_q[7:1]};
    assign pkt_inc    = (pkt_q == 2'd2) ? 2'd0 : pkt_q + 2'd1;
    // A byte still waiting to be issued already counts toward the packet position.
    assign pkt_eff    = pend_q ? pkt_inc : pkt_q;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        pend_d    = 1'b0;
        pkt_d     = pkt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        index_d   = index_q;
        pd_d      = valid_q && (index_q == 2'd2);
        active_d  = active_q;
        err_d     = err_q;

        if (pend_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            index_d = pkt_q;
            pkt_d   = pkt_inc;
        end

        if (csn_fall) begin
            bit_cnt_d = 3'd0;
            pkt_d     = 2'd0;
            active_d  = 1'b1;
        end else if (csn_rise) begin
            active_d  = 1'b0;
            bit_cnt_d = 3'd0;
            if (bit_cnt_q != 3'd0 || pkt_eff != 2'd0) begin
                err_d = 1'b1;
            end
        end else if (capture) begin
            shift_d   = shift_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b1;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            pend_q      <= 1'b0;
            pkt_q       <= 2'd0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            index_q     <= 2'd0;
            pd_q        <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck_i};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
            sck_prev_q  <= sck_s;
            csn_prev_q  <= csn_s;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            pkt_q       <= pkt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            index_q     <= index_d;
            pd_q        <= pd_d;
            active_q    <= active_d;
            err_q       <= err_d;
        end
    end

    assign data_o       = data_q;
    assign byte_valid_o = valid_q;
    assign byte_index_o = index_q;
    assign pixel_done_o = pd_q;
    assign active_o     = active_q;
    assign frame_err_o  = err_q;

`ifdef SPI_RX_MISO_ECHO_EN
    logic [7:0] tx_q;
    logic [2:0] tx_cnt_q;
    logic       sck_fall;

    assign sck_fall = ~sck_s & sck_prev_q;

    // The eighth falling edge reloads with the byte that just completed on MOSI.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_q     <= 8'h00;
            tx_cnt_q <= 3'd0;
        end else if (csn_fall) begin
            tx_q     <= data_q;
            tx_cnt_q <= 3'd0;
        end else if (sck_fall && !csn_s && active_q) begin
            if (tx_cnt_q == 3'd7) begin
                tx_q     <= data_q;
                tx_cnt_q <= 3'd0;
            end else begin
                tx_q     <= MSB_FIRST ? {tx_q[6:0], 1'b0} : {1'b0, tx_q[7:1]};
                tx_cnt_q <= tx_cnt_q + 3'd1;
            end
        end
    end

    assign spi_miso_o = MSB_FIRST ? tx_q[7] : tx_q[0];
`else
    assign spi_miso_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pixel_receiver.sv
// tb/tb_spi_pixel_receiver.sv - directed bench for spi_pixel_receiver
module tb_spi_pixel_receiver;

    localparam int S    = 2;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic rst, sck, csn, mosi;

    logic       miso_m, bv_m, pd_m, act_m, err_m;
    logic [7:0] data_m;
    logic [1:0] idx_m;
    logic       miso_l, bv_l, pd_l, act_l, err_l;
    logic [7:0] data_l;
    logic [1:0] idx_l;

    spi_pixel_receiver #(.SYNC_STAGES(S), .MSB_FIRST(1'b1)) dut_msb (
        .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_cs_n_i(csn), .spi_mosi_i(mosi),
        .spi_miso_o(miso_m), .data_o(data_m), .byte_valid_o(bv_m), .byte_index_o(idx_m),
        .pixel_done_o(pd_m), .active_o(act_m), .frame_err_o(err_m)
    );

    spi_pixel_receiver #(.SYNC_STAGES(S), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_i(clk), .rst_i(rst), .spi_sck_i(sck), .spi_cs_n_i(csn), .spi_mosi_i(mosi),
        .spi_miso_o(miso_l), .data_o(data_l), .byte_valid_o(bv_l), .byte_index_o(idx_l),
        .pixel_done_o(pd_l), .active_o(act_l), .frame_err_o(err_l)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] bv_data[$];
    logic [1:0] bv_idx[$];
    int         bv_cyc[$];
    int         rise_cyc[$];
    int         pd_cnt    = 0;
    logic       prev_idx2 = 1'b0;
    logic       miso_hi   = 1'b0;
    logic       echo_en   = 1'b0;
    logic [7:0] echo_bits = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (pd_m) begin
                check_eq("pd_after_idx2", 32'(prev_idx2), 32'd1);
                pd_cnt++;
            end
            if (bv_m) begin
                bv_data.push_back(data_m);
                bv_idx.push_back(idx_m);
                bv_cyc.push_back(cyc);
            end
        end
        prev_idx2 = bv_m && (idx_m == 2'd2);
        if (miso_m || miso_l) miso_hi = 1'b1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            wait_clk(HALF);
            if (echo_en) echo_bits = {echo_bits[6:0], miso_m};
            sck = 1'b1;
            if (i == 0) rise_cyc.push_back(cyc);
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic start_frame();
        csn = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic end_frame();
        wait_clk(HALF);
        csn = 1'b1;
        wait_clk(10);
    endtask

    task automatic clear_log();
        bv_data.delete();
        bv_idx.delete();
        bv_cyc.delete();
        rise_cyc.delete();
        pd_cnt = 0;
    endtask

    function automatic logic [31:0] got_data(input int i);
        return (i < bv_data.size()) ? 32'(bv_data[i]) : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] got_idx(input int i);
        return (i < bv_idx.size()) ? 32'(bv_idx[i]) : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] got_lat(input int i);
        return (i < bv_cyc.size() && i < rise_cyc.size()) ? 32'(bv_cyc[i] - rise_cyc[i]) : 32'hxxxx_xxxx;
    endfunction

    initial begin
        logic [7:0] pkt1[3];
        logic [7:0] pkt6[6];
        pkt1 = '{8'h15, 8'h2A, 8'hC3};
        pkt6 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

        rst = 1'b1; sck = 1'b0; csn = 1'b1; mosi = 1'b0;
        wait_clk(3);
        check_eq("rst_data", 32'(data_m), 32'h00);
        check_eq("rst_valid", 32'(bv_m), 32'd0);
        check_eq("rst_index", 32'(idx_m), 32'd0);
        check_eq("rst_pd", 32'(pd_m), 32'd0);
        check_eq("rst_active", 32'(act_m), 32'd0);
        check_eq("rst_err", 32'(err_m), 32'd0);
        check_eq("rst_miso", 32'(miso_m), 32'd0);
        rst = 1'b0;
        wait_clk(5);

        clear_log();
        start_frame();
        check_eq("active_in_frame", 32'(act_m), 32'd1);
        for (int i = 0; i < 3; i++) send_bits(pkt1[i], 8);
        end_frame();
        check_eq("single_count", 32'(bv_data.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("single_data%0d", i), got_data(i), 32'(pkt1[i]));
            check_eq($sformatf("single_idx%0d", i), got_idx(i), 32'(i));
            check_eq($sformatf("single_latency%0d", i), got_lat(i), 32'(S + 2));
        end
        check_eq("single_pd_count", 32'(pd_cnt), 32'd1);
        check_eq("single_err", 32'(err_m), 32'd0);
        check_eq("active_after_frame", 32'(act_m), 32'd0);

        clear_log();
        start_frame();
        for (int i = 0; i < 6; i++) send_bits(pkt6[i], 8);
        end_frame();
        check_eq("b2b_count", 32'(bv_data.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_eq($sformatf("b2b_data%0d", i), got_data(i), 32'(pkt6[i]));
            check_eq($sformatf("b2b_idx%0d", i), got_idx(i), 32'(i % 3));
        end
        check_eq("b2b_pd_count", 32'(pd_cnt), 32'd2);
        check_eq("b2b_err", 32'(err_m), 32'd0);

        clear_log();
        start_frame();
        send_bits(8'h11, 8);
        send_bits(8'h22, 5);
        end_frame();
        check_eq("abort_count", 32'(bv_data.size()), 32'd1);
        check_eq("abort_data", 32'(data_m), 32'h11);
        check_eq("abort_err", 32'(err_m), 32'd1);
        clear_log();
        start_frame();
        send_bits(8'h33, 8);
        end_frame();
        check_eq("after_abort_data", got_data(0), 32'h33);
        check_eq("after_abort_idx", got_idx(0), 32'd0);
        check_eq("err_sticky", 32'(err_m), 32'd1);

        clear_log();
        start_frame();
        send_bits(8'h80, 8);
        end_frame();
        check_eq("lsb_first_data", 32'(data_l), 32'h01);
        check_eq("msb_first_data", 32'(data_m), 32'h80);

        clear_log();
        for (int i = 0; i < 8; i++) begin
            mosi = 1'b1;
            wait_clk(HALF);
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
        wait_clk(10);
        check_eq("gated_count", 32'(bv_data.size()), 32'd0);
        check_eq("gated_data", 32'(data_m), 32'h80);
        check_eq("gated_active", 32'(act_m), 32'd0);

        clear_log();
        start_frame();
        send_bits(8'hA5, 8);
        echo_en = 1'b1;
        send_bits(8'h3C, 8);
        echo_en = 1'b0;
        end_frame();
        check_eq("echo_rx_data", got_data(1), 32'h3C);
`ifdef SPI_RX_MISO_ECHO_EN
        check_eq("echo_bits", 32'(echo_bits), 32'hA5);
`else
        check_eq("miso_tied_low", 32'(miso_hi), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
